// File: rtl/shim_pkg.sv
// Shared constants and types for the shim queue write/read logic.
//   - 66b sync header encodings
//   - control block type codes used for packet framing
//   - truncation block payload written when a packet must be force-closed
//   - write-controller FSM state type
package shim_pkg;

  localparam logic [1:0]  SYNC_DATA = 2'b10;
  localparam logic [1:0]  SYNC_CTRL = 2'b01;

  localparam logic [7:0]  BT_START0 = 8'h78;
  localparam logic [7:0]  BT_START4 = 8'h33;

  // Control block types strictly above this value terminate a packet.
  localparam logic [7:0]  TERM_MIN  = 8'h86;

  // Payload of the TERM block written in place of an offending block.
  localparam logic [63:0] TRUNC_D   = 64'h0000_0000_0000_0087;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } state_t;

endpackage

// File: rtl/shim_blk_classify.sv
// Combinational 66b block classifier, shared by writer and reader logic.
// Ports:
//   sync     in  2  sync header of the block
//   blk_type in  8  payload[7:0] (block type when sync is control)
//   is_start out 1  control block opening a packet
//   is_term  out 1  control block closing a packet
//   is_bad   out 1  invalid sync header (2'b00 or 2'b11)
module shim_blk_classify
  import shim_pkg::*;
(
  input  logic [1:0] sync,
  input  logic [7:0] blk_type,
  output logic       is_start,
  output logic       is_term,
  output logic       is_bad
);

  logic is_ctrl_s;

  // Decode sync header and block type into framing classes.
  always_comb begin
    is_ctrl_s = (sync == SYNC_CTRL);
    is_start  = is_ctrl_s && ((blk_type == BT_START0) || (blk_type == BT_START4));
    is_term   = is_ctrl_s && (blk_type > TERM_MIN);
    is_bad    = (sync == 2'b00) || (sync == 2'b11);
  end

endmodule

// File: rtl/shim_write_ctrl.sv
// Write-side controller of the shim queue.
// Admits whole packets only when the queue can absorb a maximum-length
// packet, strips inter-packet idles, and guarantees every admitted packet is
// closed by a TERM (a TRUNC_D block is substituted when a packet overruns,
// carries a bad header, or is interrupted by a new START).
// Ports:
//   clk, rst             block clock, async active-high reset
//   in_valid             shim_inc/shim_ind carry a block this cycle
//   shim_inc / shim_ind  incoming sync header / payload
//   shimq_level          queue occupancy, sampled at admission only
//   shimq_write/wc/wd    registered queue write port
//   pkt_done, trunc_err  one-cycle pulses on TERM / truncation TERM writes
//   pkt_cnt              packets written (wrapping)
//   drop_cnt             packets refused admission (saturating)
module shim_write_ctrl
  import shim_pkg::*;
#(
  parameter int DEPTH          = 512,
  parameter int MAX_PKT_BLOCKS = 200,
  parameter int LEVEL_W        = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         shim_inc,
  input  logic [63:0]        shim_ind,
  input  logic [LEVEL_W-1:0] shimq_level,
  output logic               shimq_write,
  output logic [1:0]         shimq_wc,
  output logic [63:0]        shimq_wd,
  output logic               pkt_done,
  output logic               trunc_err,
  output logic [31:0]        pkt_cnt,
  output logic [15:0]        drop_cnt
);

  localparam int BLK_W = $clog2(MAX_PKT_BLOCKS) + 1;
  // Free space >= MAX_PKT_BLOCKS is equivalent to level <= DEPTH - MAX_PKT_BLOCKS,
  // which avoids an underflowing subtraction on the level input.
  localparam logic [LEVEL_W-1:0] ADMIT_MAX_LEVEL = LEVEL_W'(DEPTH - MAX_PKT_BLOCKS);
  localparam logic [BLK_W-1:0]   LAST_BLK        = BLK_W'(MAX_PKT_BLOCKS - 1);

  state_t            state_r, state_nxt_s;
  logic [BLK_W-1:0]  blk_cnt_r, blk_cnt_nxt_s;
  logic              is_start_s, is_term_s, is_bad_s;
  logic              room_s, at_limit_s;
  logic              wr_s, done_s, trunc_s, pkt_inc_s, drop_inc_s;
  logic [1:0]        wc_s;
  logic [63:0]       wd_s;

  shim_blk_classify u_classify (
    .sync     (shim_inc),
    .blk_type (shim_ind[7:0]),
    .is_start (is_start_s),
    .is_term  (is_term_s),
    .is_bad   (is_bad_s)
  );

  assign room_s     = (shimq_level <= ADMIT_MAX_LEVEL);
  assign at_limit_s = (blk_cnt_r == LAST_BLK);

  // Next-state and next-output decode; in_valid=0 leaves all state untouched.
  always_comb begin
    state_nxt_s   = state_r;
    blk_cnt_nxt_s = blk_cnt_r;
    wr_s          = 1'b0;
    wc_s          = 2'b00;
    wd_s          = 64'h0;
    done_s        = 1'b0;
    trunc_s       = 1'b0;
    pkt_inc_s     = 1'b0;
    drop_inc_s    = 1'b0;
    if (in_valid) begin
      case (state_r)
        IDLE: begin
          if (is_start_s && room_s) begin
            wr_s          = 1'b1;
            wc_s          = shim_inc;
            wd_s          = shim_ind;
            blk_cnt_nxt_s = BLK_W'(1);
            state_nxt_s   = IN_PKT;
          end else if (is_start_s) begin
            drop_inc_s  = 1'b1;
            state_nxt_s = DROP;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        IN_PKT: begin
          // TERM is checked first so a TERM landing on the last slot closes
          // the packet normally instead of being truncated.
          if (is_term_s) begin
            wr_s        = 1'b1;
            wc_s        = shim_inc;
            wd_s        = shim_ind;
            done_s      = 1'b1;
            pkt_inc_s   = 1'b1;
            state_nxt_s = IDLE;
          end else if (at_limit_s || is_bad_s || is_start_s) begin
            wr_s        = 1'b1;
            wc_s        = SYNC_CTRL;
            wd_s        = TRUNC_D;
            done_s      = 1'b1;
            trunc_s     = 1'b1;
            pkt_inc_s   = 1'b1;
            state_nxt_s = DROP;
          end else begin
            wr_s          = 1'b1;
            wc_s          = shim_inc;
            wd_s          = shim_ind;
            blk_cnt_nxt_s = blk_cnt_r + BLK_W'(1);
          end
        end
        DROP: begin
          if (is_term_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DROP;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, block counter and registered queue-write outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      blk_cnt_r   <= '0;
      shimq_write <= 1'b0;
      shimq_wc    <= 2'b00;
      shimq_wd    <= 64'h0;
      pkt_done    <= 1'b0;
      trunc_err   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      blk_cnt_r   <= blk_cnt_nxt_s;
      shimq_write <= wr_s;
      shimq_wc    <= wc_s;
      shimq_wd    <= wd_s;
      pkt_done    <= done_s;
      trunc_err   <= trunc_s;
    end
  end

  // Packet (wrapping) and drop (saturating) statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= 32'h0;
      drop_cnt <= 16'h0;
    end else begin
      if (pkt_inc_s) begin
        pkt_cnt <= pkt_cnt + 32'h1;
      end
      if (drop_inc_s && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'h1;
      end
    end
  end

endmodule

// File: tb/tb_shim_write_ctrl.sv
// Directed bench for shim_write_ctrl with a scoreboard: the stimulus side
// pushes the expected queue writes, a negedge monitor pops and compares.
module tb_shim_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  shim_inc = 2'b00;
  logic [63:0] shim_ind = 64'h0;
  logic [9:0]  shimq_level = 10'd0;
  logic        shimq_write;
  logic [1:0]  shimq_wc;
  logic [63:0] shimq_wd;
  logic        pkt_done;
  logic        trunc_err;
  logic [31:0] pkt_cnt;
  logic [15:0] drop_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Expected write: {wc, wd, pkt_done, trunc_err}
  logic [67:0] exp_q[$];

  localparam logic [63:0] START_D = 64'hA5A5_0000_0000_0078;
  localparam logic [63:0] TERM_D  = 64'h0000_0000_0000_0087;
  localparam logic [63:0] IDLE_D  = 64'h0000_0000_0000_001E;

  shim_write_ctrl #(.DEPTH(512), .MAX_PKT_BLOCKS(200), .LEVEL_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .shim_inc    (shim_inc),
    .shim_ind    (shim_ind),
    .shimq_level (shimq_level),
    .shimq_write (shimq_write),
    .shimq_wc    (shimq_wc),
    .shimq_wd    (shimq_wd),
    .pkt_done    (pkt_done),
    .trunc_err   (trunc_err),
    .pkt_cnt     (pkt_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_wr(input logic [1:0] wc, input logic [63:0] wd,
                           input logic done, input logic trunc);
    exp_q.push_back({wc, wd, done, trunc});
  endtask

  // Present one valid block for one cycle.
  task automatic send(input logic [1:0] s, input logic [63:0] d);
    in_valid = 1'b1;
    shim_inc = s;
    shim_ind = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Block expected to pass straight through to the queue.
  task automatic send_wr(input logic [1:0] s, input logic [63:0] d);
    expect_wr(s, d, 1'b0, 1'b0);
    send(s, d);
  endtask

  // Invalid cycles carrying START-looking garbage, which must be ignored.
  task automatic gap(input int n);
    in_valid = 1'b0;
    shim_inc = 2'b01;
    shim_ind = START_D;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (shimq_write) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_write: got wc=%b wd=%h expected no write", shimq_wc, shimq_wd);
        end else begin
          chk("queue_write", {shimq_wc, shimq_wd, pkt_done, trunc_err}, exp_q.pop_front());
        end
      end else if (pkt_done || trunc_err) begin
        total_cnt++;
        $display("FAIL stray_pulse: got done=%b trunc=%b expected 0 0", pkt_done, trunc_err);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", 68'(shimq_write), 68'd0);
    chk("rst_pulses", 68'({pkt_done, trunc_err}), 68'd0);
    chk("rst_pkt_cnt", 68'(pkt_cnt), 68'd0);
    chk("rst_drop_cnt", 68'(drop_cnt), 68'd0);
    rst = 1'b0;
    gap(2);

    // Basic packet; the leading idle is stripped.
    send(2'b01, IDLE_D);
    send_wr(2'b01, START_D);
    for (int i = 0; i < 3; i++) send_wr(2'b10, 64'h1111_0000_0000_0000 + 64'(i));
    expect_wr(2'b01, TERM_D, 1'b1, 1'b0);
    send(2'b01, TERM_D);
    gap(2);
    chk("basic_pkt_cnt", 68'(pkt_cnt), 68'd1);
    chk("basic_drop_cnt", 68'(drop_cnt), 68'd0);

    // Free space 199: refused, nothing written.
    shimq_level = 10'd313;
    send(2'b01, START_D);
    for (int i = 0; i < 3; i++) send(2'b10, 64'h2222_0000_0000_0000 + 64'(i));
    send(2'b01, TERM_D);
    gap(2);
    chk("drop_drop_cnt", 68'(drop_cnt), 68'd1);
    chk("drop_pkt_cnt", 68'(pkt_cnt), 68'd1);

    // Level only sampled at admission; free space exactly 200 admits.
    shimq_level = 10'd312;
    send_wr(2'b01, START_D);
    shimq_level = 10'd500;
    send_wr(2'b10, 64'h3333_0000_0000_0001);
    gap(1);
    send_wr(2'b10, 64'h3333_0000_0000_0002);
    expect_wr(2'b01, 64'h0000_0000_0000_00FF, 1'b1, 1'b0);
    send(2'b01, 64'h0000_0000_0000_00FF);
    gap(2);
    chk("edge_room_pkt_cnt", 68'(pkt_cnt), 68'd2);
    shimq_level = 10'd0;

    // Overlong packet: 199 blocks then TRUNC, rest dropped through TERM.
    send_wr(2'b01, START_D);
    for (int j = 1; j <= 250; j++) begin
      if (j < 199) send_wr(2'b10, 64'h4444_0000_0000_0000 + 64'(j));
      else if (j == 199) begin
        expect_wr(2'b01, TERM_D, 1'b1, 1'b1);
        send(2'b10, 64'h4444_0000_0000_0000 + 64'(j));
      end else send(2'b10, 64'h4444_0000_0000_0000 + 64'(j));
    end
    send(2'b01, TERM_D);
    gap(2);
    chk("long_pkt_cnt", 68'(pkt_cnt), 68'd3);

    // TERM exactly on the last slot is written normally.
    send_wr(2'b01, START_D);
    for (int j = 1; j <= 198; j++) send_wr(2'b10, 64'h5555_0000_0000_0000 + 64'(j));
    expect_wr(2'b01, 64'h0000_0000_0000_0099, 1'b1, 1'b0);
    send(2'b01, 64'h0000_0000_0000_0099);
    gap(2);
    chk("limit_term_pkt_cnt", 68'(pkt_cnt), 68'd4);

    // BAD sync mid-packet.
    send_wr(2'b01, START_D);
    send_wr(2'b10, 64'h6666_0000_0000_0001);
    expect_wr(2'b01, TERM_D, 1'b1, 1'b1);
    send(2'b11, 64'h6666_0000_0000_0002);
    send(2'b10, 64'h6666_0000_0000_0003);
    send(2'b01, TERM_D);
    gap(2);
    chk("bad_pkt_cnt", 68'(pkt_cnt), 68'd5);

    // New START mid-packet; second packet discarded; stray TERM in IDLE.
    send_wr(2'b01, START_D);
    send_wr(2'b10, 64'h7777_0000_0000_0001);
    send_wr(2'b10, 64'h7777_0000_0000_0002);
    expect_wr(2'b01, TERM_D, 1'b1, 1'b1);
    send(2'b01, 64'h0000_0000_0000_0033);
    send(2'b10, 64'h7777_0000_0000_0003);
    send(2'b01, TERM_D);
    send(2'b01, TERM_D);
    send(2'b10, 64'h7777_0000_0000_0004);
    gap(2);
    chk("restart_pkt_cnt", 68'(pkt_cnt), 68'd6);
    chk("restart_drop_cnt", 68'(drop_cnt), 68'd1);

    // Asynchronous reset mid-packet.
    send_wr(2'b01, START_D);
    send(2'b10, 64'h8888_0000_0000_0001);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_write", 68'(shimq_write), 68'd0);
    chk("async_rst_pkt_cnt", 68'(pkt_cnt), 68'd0);
    chk("async_rst_drop_cnt", 68'(drop_cnt), 68'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(2'b10, 64'h8888_0000_0000_0002);
    send_wr(2'b01, START_D);
    expect_wr(2'b01, TERM_D, 1'b1, 1'b0);
    send(2'b01, TERM_D);
    gap(3);
    chk("post_rst_pkt_cnt", 68'(pkt_cnt), 68'd1);
    chk("scoreboard_drained", 68'(exp_q.size()), 68'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
